// File: rtl/snake_body_scanner_pkg.sv
// Shared types for the snake-body segment path: the default coordinate width,
// the scanner state encoding and the {x, y} word packing.
package snake_body_scanner_pkg;

   localparam int SBS_COORD_W = 8;
   localparam int SBS_DEPTH   = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // x occupies the upper half of a FIFO word.
   typedef struct packed {
      logic [SBS_COORD_W-1:0] x;
      logic [SBS_COORD_W-1:0] y;
   } coord_t;

   function automatic logic [2*SBS_COORD_W-1:0] pack_xy(
      input logic [SBS_COORD_W-1:0] x,
      input logic [SBS_COORD_W-1:0] y
   );
      return {x, y};
   endfunction

   function automatic coord_t unpack_xy(input logic [2*SBS_COORD_W-1:0] w);
      return coord_t'(w);
   endfunction

endpackage

// File: rtl/snake_body_scanner.sv
// Snake-body FIFO scanner: pops every stored segment once, compares it with a
// latched query coordinate and pushes it straight back, so the ring is unchanged.
//
// state    | meaning
// ST_IDLE  | waiting for start; query, flags and length latched on accept
// ST_SCAN  | one FIFO pop per cycle until length pops issued
// ST_DRAIN | last compare / write-back of the final popped segment
// ST_DONE  | one-cycle done pulse, results valid
module snake_body_scanner
   import snake_body_scanner_pkg::*;
#(
   parameter int COORD_W = SBS_COORD_W,
   parameter int DEPTH   = SBS_DEPTH,
   parameter int IDX_W   = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [IDX_W-1:0]     length,
   input  logic                 skip_head,
   input  logic [COORD_W-1:0]   query_x,
   input  logic [COORD_W-1:0]   query_y,
   output logic                 fifo_read,
   output logic                 fifo_write,
   output logic [2*COORD_W-1:0] fifo_wdata,
   input  logic [2*COORD_W-1:0] fifo_rdata,
   input  logic                 fifo_empty,
   output logic                 busy,
   output logic                 done,
   output logic                 hit,
   output logic [IDX_W-1:0]     hit_index
);

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     len_q, len_d;
   logic [IDX_W-1:0]     rd_cnt_q, rd_cnt_d;
   logic [IDX_W-1:0]     cmp_cnt_q, cmp_cnt_d;
   logic [IDX_W-1:0]     hit_index_q, hit_index_d;
   logic                 skip_q, skip_d;
   logic                 hit_q, hit_d;
   logic                 rvalid_q, rvalid_d;
   logic [COORD_W-1:0]   qx_q, qx_d;
   logic [COORD_W-1:0]   qy_q, qy_d;

   logic                 accept;
   logic                 nothing_to_scan;
   logic                 last_rd;
   logic                 match;
   logic [IDX_W-1:0]     len_clamped;
   logic [2*COORD_W-1:0] query_word;

   assign len_clamped     = (length > IDX_W'(DEPTH)) ? IDX_W'(DEPTH) : length;
   assign accept          = (state_q == ST_IDLE) && start;
   assign nothing_to_scan = (len_clamped == '0) || fifo_empty;
   assign last_rd         = (rd_cnt_q == (len_q - IDX_W'(1)));
   assign query_word      = {qx_q, qy_q};
   assign match           = rvalid_q && (fifo_rdata == query_word) &&
                            !(skip_q && (cmp_cnt_q == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = nothing_to_scan ? ST_DONE : ST_SCAN;
         ST_SCAN:  if (last_rd) state_d = ST_DRAIN;
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_q       <= '0;
         rd_cnt_q    <= '0;
         cmp_cnt_q   <= '0;
         hit_index_q <= '0;
         skip_q      <= 1'b0;
         hit_q       <= 1'b0;
         rvalid_q    <= 1'b0;
         qx_q        <= '0;
         qy_q        <= '0;
      end else begin
         len_q       <= len_d;
         rd_cnt_q    <= rd_cnt_d;
         cmp_cnt_q   <= cmp_cnt_d;
         hit_index_q <= hit_index_d;
         skip_q      <= skip_d;
         hit_q       <= hit_d;
         rvalid_q    <= rvalid_d;
         qx_q        <= qx_d;
         qy_q        <= qy_d;
      end
   end

   always_comb begin
      len_d       = len_q;
      rd_cnt_d    = rd_cnt_q;
      cmp_cnt_d   = cmp_cnt_q;
      hit_index_d = hit_index_q;
      skip_d      = skip_q;
      hit_d       = hit_q;
      qx_d        = qx_q;
      qy_d        = qy_q;
      // Read data arrives one cycle after each pop; this flag marks it.
      rvalid_d    = (state_q == ST_SCAN);

      if (accept) begin
         len_d       = len_clamped;
         skip_d      = skip_head;
         qx_d        = query_x;
         qy_d        = query_y;
         rd_cnt_d    = '0;
         cmp_cnt_d   = '0;
         hit_d       = 1'b0;
         hit_index_d = '0;
      end

      if (state_q == ST_SCAN) begin
         rd_cnt_d = rd_cnt_q + IDX_W'(1);
      end

      if (rvalid_q) begin
         cmp_cnt_d = cmp_cnt_q + IDX_W'(1);
         if (match && !hit_q) begin
            hit_d       = 1'b1;
            hit_index_d = cmp_cnt_q;
         end
      end
   end

   always_comb begin
      fifo_read  = (state_q == ST_SCAN);
      fifo_write = rvalid_q;
      fifo_wdata = rvalid_q ? fifo_rdata : '0;
      busy       = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
      done       = (state_q == ST_DONE);
      hit        = hit_q;
      hit_index  = hit_index_q;
   end

endmodule

// File: tb/tb_snake_body_scanner.sv
// Bench for snake_body_scanner: a behavioural ring FIFO plus a first-match
// reference computed over the expected FIFO contents.
module tb_snake_body_scanner;
   import snake_body_scanner_pkg::*;

   localparam int CW    = SBS_COORD_W;
   localparam int DEPTH = 64;
   localparam int IDX_W = $clog2(DEPTH) + 1;
   localparam int WW    = 2 * CW;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [IDX_W-1:0] length = '0;
   logic             skip_head = 1'b0;
   logic [CW-1:0]    query_x = '0;
   logic [CW-1:0]    query_y = '0;
   logic             fifo_read, fifo_write, busy, done, hit;
   logic [WW-1:0]    fifo_wdata;
   logic [WW-1:0]    fifo_rdata = '0;
   logic             fifo_empty;
   logic [IDX_W-1:0] hit_index;

   int n_chk = 0;
   int n_err = 0;

   logic [WW-1:0] load_q[$];
   logic [WW-1:0] exp_q[$];

   always #5 clk = ~clk;

   snake_body_scanner #(.COORD_W(CW), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .length     (length),
      .skip_head  (skip_head),
      .query_x    (query_x),
      .query_y    (query_y),
      .fifo_read  (fifo_read),
      .fifo_write (fifo_write),
      .fifo_wdata (fifo_wdata),
      .fifo_rdata (fifo_rdata),
      .fifo_empty (fifo_empty),
      .busy       (busy),
      .done       (done),
      .hit        (hit),
      .hit_index  (hit_index)
   );

   // Ring FIFO with registered read data; the bench pushes/pops it directly to load it.
   logic [WW-1:0] mem [DEPTH];
   int            rd_ptr = 0;
   int            wr_ptr = 0;
   int            occ = 0;
   logic          fifo_bad = 1'b0;
   logic          tb_push = 1'b0;
   logic          tb_pop = 1'b0;
   logic [WW-1:0] tb_push_data = '0;
   wire           do_rd = fifo_read | tb_pop;
   wire           do_wr = fifo_write | tb_push;
   wire [WW-1:0]  wr_word = tb_push ? tb_push_data : fifo_wdata;

   assign fifo_empty = (occ == 0);

   always @(posedge clk) begin
      if (rst) begin
         rd_ptr     <= 0;
         wr_ptr     <= 0;
         occ        <= 0;
         fifo_rdata <= '0;
      end else begin
         if (do_rd) begin
            if (occ == 0) fifo_bad <= 1'b1;
            fifo_rdata <= mem[rd_ptr];
            rd_ptr     <= (rd_ptr + 1) % DEPTH;
         end
         if (do_wr) begin
            if (occ == DEPTH && !do_rd) fifo_bad <= 1'b1;
            if (tb_push && fifo_write) fifo_bad <= 1'b1;
            mem[wr_ptr] <= wr_word;
            wr_ptr      <= (wr_ptr + 1) % DEPTH;
         end
         occ <= occ + (do_wr ? 1 : 0) - (do_rd ? 1 : 0);
      end
   end

   function automatic int ref_first_match(input logic [WW-1:0] w, input bit skip);
      for (int i = 0; i < exp_q.size(); i++)
         if (exp_q[i] == w && !(skip && i == 0)) return i;
      return -1;
   endfunction

   function automatic int fifo_diff();
      int d;
      d = (occ != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < exp_q.size(); i++)
         if (mem[(rd_ptr + i) % DEPTH] !== exp_q[i]) d++;
      return d;
   endfunction

   task automatic fifo_load(input int rotate);
      int guard;
      @(negedge clk);
      guard  = 0;
      tb_pop = 1'b1;
      while (occ != 0 && guard < 2 * DEPTH) begin
         @(negedge clk);
         guard++;
      end
      tb_pop = 1'b0;
      for (int i = 0; i < rotate; i++) begin
         tb_push = 1'b1;
         tb_push_data = WW'(i);
         @(negedge clk);
      end
      tb_push = 1'b0;
      for (int i = 0; i < rotate; i++) begin
         tb_pop = 1'b1;
         @(negedge clk);
      end
      tb_pop = 1'b0;
      foreach (load_q[i]) begin
         tb_push = 1'b1;
         tb_push_data = load_q[i];
         @(negedge clk);
      end
      tb_push = 1'b0;
      exp_q = load_q;
   endtask

   // Issues one start and observes until done (bounded); returns what was seen.
   task automatic do_scan(input int len, input bit skip, input logic [CW-1:0] qx,
                          input logic [CW-1:0] qy, output int done_cyc, output int nrd,
                          output int nwr, output logic h, output logic [IDX_W-1:0] hi,
                          output int busy_cyc);
      @(negedge clk);
      length = IDX_W'(len);
      skip_head = skip;
      query_x = qx;
      query_y = qy;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      query_x = ~qx;
      query_y = ~qy;
      skip_head = ~skip;
      length = '0;
      done_cyc = -1;
      nrd = 0;
      nwr = 0;
      busy_cyc = 0;
      h = 1'b0;
      hi = '0;
      for (int c = 1; c <= 200; c++) begin
         if (fifo_read) nrd++;
         if (fifo_write) nwr++;
         if (busy) busy_cyc++;
         if (done) begin
            done_cyc = c;
            h = hit;
            hi = hit_index;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({busy, done, fifo_read, fifo_write} !== 4'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b want 0000", {busy, done, fifo_read, fifo_write});
      end
      n_chk++;
      if (fifo_wdata !== '0 || hit !== 1'b0 || hit_index !== '0) begin
         n_err++;
         $display("FAIL reset_data: wdata=%h hit=%b idx=%0d want 0/0/0", fifo_wdata, hit, hit_index);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({busy, done, fifo_read, fifo_write, hit} !== 5'b0) begin
         n_err++;
         $display("FAIL idle_after_reset: got %b want 00000", {busy, done, fifo_read, fifo_write, hit});
      end
   endtask

   task automatic test_basic();
      int dc, nr, nw, bc;
      logic h;
      logic [IDX_W-1:0] hi;
      load_q = '{pack_xy(8'd3, 8'd4), pack_xy(8'd3, 8'd5), pack_xy(8'd3, 8'd6)};
      fifo_load(0);
      do_scan(3, 1'b0, 8'd3, 8'd5, dc, nr, nw, h, hi, bc);
      n_chk++;
      if (dc != 5) begin n_err++; $display("FAIL basic_done_cycle: got %0d want 5", dc); end
      n_chk++;
      if (h !== 1'b1 || hi !== IDX_W'(1)) begin
         n_err++; $display("FAIL basic_hit: got hit=%b idx=%0d want 1/1", h, hi);
      end
      n_chk++;
      if (nr != 3 || nw != 3 || bc != 4) begin
         n_err++; $display("FAIL basic_strobes: rd=%0d wr=%0d busy=%0d want 3/3/4", nr, nw, bc);
      end
      n_chk++;
      if (fifo_diff() != 0) begin n_err++; $display("FAIL basic_order: %0d diffs want 0", fifo_diff()); end
      do_scan(3, 1'b1, 8'd3, 8'd4, dc, nr, nw, h, hi, bc);
      n_chk++;
      if (h !== 1'b0 || hi !== '0) begin
         n_err++; $display("FAIL skip_head: got hit=%b idx=%0d want 0/0", h, hi);
      end
      do_scan(3, 1'b0, 8'd3, 8'd4, dc, nr, nw, h, hi, bc);
      n_chk++;
      if (h !== 1'b1 || hi !== '0) begin
         n_err++; $display("FAIL head_match: got hit=%b idx=%0d want 1/0", h, hi);
      end
   endtask

   task automatic test_duplicate();
      int dc, nr, nw, bc;
      logic h;
      logic [IDX_W-1:0] hi;
      load_q = '{pack_xy(8'd1, 8'd1), pack_xy(8'd2, 8'd2), pack_xy(8'd7, 8'd7),
                 pack_xy(8'd3, 8'd3), pack_xy(8'd7, 8'd7), pack_xy(8'd4, 8'd4)};
      fifo_load(5);
      do_scan(6, 1'b0, 8'd7, 8'd7, dc, nr, nw, h, hi, bc);
      n_chk++;
      if (h !== 1'b1 || hi !== IDX_W'(2) || dc != 8) begin
         n_err++; $display("FAIL duplicate: got hit=%b idx=%0d done=%0d want 1/2/8", h, hi, dc);
      end
      n_chk++;
      if (fifo_diff() != 0) begin n_err++; $display("FAIL duplicate_order: %0d diffs want 0", fifo_diff()); end
   endtask

   task automatic test_zero_length();
      int dc, nr, nw, bc;
      logic h;
      logic [IDX_W-1:0] hi;
      do_scan(0, 1'b0, 8'd7, 8'd7, dc, nr, nw, h, hi, bc);
      n_chk++;
      if (dc != 1 || nr != 0 || nw != 0 || bc != 0) begin
         n_err++; $display("FAIL len0: done=%0d rd=%0d wr=%0d busy=%0d want 1/0/0/0", dc, nr, nw, bc);
      end
      n_chk++;
      if (h !== 1'b0 || hi !== '0) begin
         n_err++; $display("FAIL len0_hit: got hit=%b idx=%0d want 0/0", h, hi);
      end
      load_q.delete();
      fifo_load(0);
      do_scan(3, 1'b0, 8'd0, 8'd0, dc, nr, nw, h, hi, bc);
      n_chk++;
      if (dc != 1 || nr != 0 || nw != 0 || h !== 1'b0) begin
         n_err++; $display("FAIL empty_fifo: done=%0d rd=%0d wr=%0d hit=%b want 1/0/0/0", dc, nr, nw, h);
      end
   endtask

   task automatic test_full_wrap();
      int dc, nr, nw, bc;
      logic h;
      logic [IDX_W-1:0] hi;
      load_q.delete();
      for (int i = 0; i < DEPTH; i++) load_q.push_back(pack_xy(CW'(i), CW'(255 - i)));
      fifo_load(23);
      do_scan(DEPTH, 1'b0, 8'd63, 8'd192, dc, nr, nw, h, hi, bc);
      n_chk++;
      if (dc != 66 || h !== 1'b1 || hi !== IDX_W'(63)) begin
         n_err++; $display("FAIL full: done=%0d hit=%b idx=%0d want 66/1/63", dc, h, hi);
      end
      n_chk++;
      if (nr != 64 || nw != 64 || fifo_diff() != 0) begin
         n_err++; $display("FAIL full_order: rd=%0d wr=%0d diffs=%0d want 64/64/0", nr, nw, fifo_diff());
      end
      do_scan(127, 1'b0, 8'd63, 8'd192, dc, nr, nw, h, hi, bc);
      n_chk++;
      if (dc != 66 || nr != 64 || hi !== IDX_W'(63) || fifo_diff() != 0) begin
         n_err++; $display("FAIL clamp: done=%0d rd=%0d idx=%0d want 66/64/63", dc, nr, hi);
      end
   endtask

   task automatic test_random();
      int dc, nr, nw, bc, n, m;
      logic h;
      logic [IDX_W-1:0] hi;
      logic [CW-1:0] qx, qy;
      bit skip;
      for (int it = 0; it < 40; it++) begin
         n = $urandom_range(1, 24);
         load_q.delete();
         for (int i = 0; i < n; i++)
            load_q.push_back(pack_xy(CW'($urandom_range(0, 3)), CW'($urandom_range(0, 3))));
         fifo_load($urandom_range(0, 63));
         qx = CW'($urandom_range(0, 3));
         qy = CW'($urandom_range(0, 3));
         skip = 1'($urandom_range(0, 1));
         m = ref_first_match(pack_xy(qx, qy), skip);
         do_scan(n, skip, qx, qy, dc, nr, nw, h, hi, bc);
         n_chk++;
         if (dc != n + 2 || nr != n || nw != n) begin
            n_err++; $display("FAIL rand_timing it=%0d: done=%0d rd=%0d wr=%0d want %0d/%0d/%0d", it, dc, nr, nw, n + 2, n, n);
         end
         n_chk++;
         if (h !== (m >= 0) || hi !== IDX_W'((m >= 0) ? m : 0)) begin
            n_err++; $display("FAIL rand_hit it=%0d: got hit=%b idx=%0d want %0d/%0d", it, h, hi, (m >= 0), (m >= 0) ? m : 0);
         end
         n_chk++;
         if (fifo_diff() != 0) begin n_err++; $display("FAIL rand_order it=%0d: %0d diffs want 0", it, fifo_diff()); end
      end
   endtask

   task automatic test_reset_mid_scan();
      load_q.delete();
      for (int i = 0; i < 20; i++)
         load_q.push_back((i == 2) ? pack_xy(8'd200, 8'd200) : pack_xy(CW'(i + 10), CW'(i + 20)));
      fifo_load(0);
      @(negedge clk);
      length = IDX_W'(20);
      skip_head = 1'b0;
      query_x = 8'd200;
      query_y = 8'd200;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      n_chk++;
      if ({busy, fifo_read, fifo_write, hit} !== 4'b1111 || hit_index !== IDX_W'(2)) begin
         n_err++; $display("FAIL mid_scan_c10: busy/rd/wr/hit=%b idx=%0d want 1111/2", {busy, fifo_read, fifo_write, hit}, hit_index);
      end
      rst = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({busy, done, fifo_read, fifo_write, hit} !== 5'b0 || fifo_wdata !== '0 || hit_index !== '0) begin
         n_err++; $display("FAIL rst_mid_scan: ctrl=%b wdata=%h idx=%0d want 0", {busy, done, fifo_read, fifo_write, hit}, fifo_wdata, hit_index);
      end
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int first_done, second_done, rd_first, rd_total;
      logic busy8, rd9, h2;
      logic [IDX_W-1:0] hi2;
      load_q = '{pack_xy(8'd0, 8'd1), pack_xy(8'd0, 8'd2), pack_xy(8'd0, 8'd3),
                 pack_xy(8'd5, 8'd5), pack_xy(8'd0, 8'd4)};
      fifo_load(40);
      @(negedge clk);
      length = IDX_W'(5);
      skip_head = 1'b0;
      query_x = 8'd5;
      query_y = 8'd5;
      start = 1'b1;
      first_done = -1;
      second_done = -1;
      rd_first = 0;
      rd_total = 0;
      busy8 = 1'b1;
      rd9 = 1'b0;
      h2 = 1'b0;
      hi2 = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (fifo_read) rd_total++;
         if (fifo_read && first_done < 0) rd_first++;
         if (c == 8) busy8 = busy;
         if (c == 9) begin rd9 = fifo_read; start = 1'b0; end
         if (done) begin
            if (first_done < 0) first_done = c;
            else if (second_done < 0) begin second_done = c; h2 = hit; hi2 = hit_index; end
         end
      end
      n_chk++;
      if (first_done != 7 || rd_first != 5) begin
         n_err++; $display("FAIL held_first: done=%0d reads=%0d want 7/5", first_done, rd_first);
      end
      n_chk++;
      if (busy8 !== 1'b0 || rd9 !== 1'b1) begin
         n_err++; $display("FAIL held_restart: busy@8=%b rd@9=%b want 0/1", busy8, rd9);
      end
      n_chk++;
      if (second_done != 15 || rd_total != 10 || h2 !== 1'b1 || hi2 !== IDX_W'(3)) begin
         n_err++; $display("FAIL held_second: done=%0d reads=%0d hit=%b idx=%0d want 15/10/1/3", second_done, rd_total, h2, hi2);
      end
      n_chk++;
      if (fifo_diff() != 0) begin n_err++; $display("FAIL held_order: %0d diffs want 0", fifo_diff()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_duplicate();
      test_zero_length();
      test_full_wrap();
      test_random();
      test_reset_mid_scan();
      test_back_to_back();
      n_chk++;
      if (fifo_bad !== 1'b0) begin
         n_err++; $display("FAIL fifo_protocol: overflow/underflow flag=%b want 0", fifo_bad);
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
